// File: rtl/me_frame_scheduler.sv
// Frame-level scheduler for the motion-estimation core.
// Walks every macroblock of a frame in raster order: stage via the loader,
// kick the ME core, capture its SAD (or a watchdog timeout), hand the result
// downstream over valid/ready and keep a saturating frame SAD total.
module me_frame_scheduler #(
   parameter int FRAME_W_MB = 20,
   parameter int FRAME_H_MB = 15,
   parameter int TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   output logic        busy,
   output logic        frame_done,
   output logic        load_req,
   output logic [7:0]  load_mb_x,
   output logic [7:0]  load_mb_y,
   input  logic        load_ack,
   output logic        me_start,
   input  logic        me_valid,
   input  logic [15:0] me_min_sad,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_mb_x,
   output logic [7:0]  res_mb_y,
   output logic [15:0] res_sad,
   output logic        res_timeout,
   output logic        res_last,
   output logic [23:0] frame_sad
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_EMIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [7:0]  LAST_X  = 8'(FRAME_W_MB - 1);
   localparam logic [7:0]  LAST_Y  = 8'(FRAME_H_MB - 1);
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  mb_x_q, mb_x_d;
   logic [7:0]  mb_y_q, mb_y_d;
   logic [15:0] wd_q, wd_d;
   logic [15:0] res_sad_q, res_sad_d;
   logic        res_timeout_q, res_timeout_d;
   logic [7:0]  res_mb_x_q, res_mb_x_d;
   logic [7:0]  res_mb_y_q, res_mb_y_d;
   logic        res_last_q, res_last_d;
   logic [23:0] frame_sad_q, frame_sad_d;
   logic [24:0] sad_sum;

   // Timeout results already carry 16'hFFFF in res_sad, so one adder covers both cases.
   assign sad_sum = {1'b0, frame_sad_q} + {9'd0, res_sad_q};

   // Next-state and datapath update; every register holds unless its state acts on it.
   always_comb begin
      state_d       = state_q;
      mb_x_d        = mb_x_q;
      mb_y_d        = mb_y_q;
      wd_d          = wd_q;
      res_sad_d     = res_sad_q;
      res_timeout_d = res_timeout_q;
      res_mb_x_d    = res_mb_x_q;
      res_mb_y_d    = res_mb_y_q;
      res_last_d    = res_last_q;
      frame_sad_d   = frame_sad_q;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               mb_x_d      = 8'd0;
               mb_y_d      = 8'd0;
               wd_d        = 16'd0;
               frame_sad_d = 24'd0;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_ack) state_d = S_START;
         end
         S_START: begin
            wd_d    = 16'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A core result in the expiry cycle takes priority over the watchdog.
            if (me_valid || (wd_q == WD_LAST)) begin
               res_sad_d     = me_valid ? me_min_sad : 16'hFFFF;
               res_timeout_d = ~me_valid;
               res_mb_x_d    = mb_x_q;
               res_mb_y_d    = mb_y_q;
               res_last_d    = (mb_x_q == LAST_X) && (mb_y_q == LAST_Y);
               state_d       = S_EMIT;
            end else begin
               wd_d = wd_q + 16'd1;
            end
         end
         S_EMIT: begin
            if (res_ready) begin
               frame_sad_d = sad_sum[24] ? 24'hFFFFFF : sad_sum[23:0];
               if (mb_x_q == LAST_X) begin
                  mb_x_d = 8'd0;
                  mb_y_d = mb_y_q + 8'd1;
               end else begin
                  mb_x_d = mb_x_q + 8'd1;
               end
               state_d = res_last_q ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset to all-zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         mb_x_q        <= 8'd0;
         mb_y_q        <= 8'd0;
         wd_q          <= 16'd0;
         res_sad_q     <= 16'd0;
         res_timeout_q <= 1'b0;
         res_mb_x_q    <= 8'd0;
         res_mb_y_q    <= 8'd0;
         res_last_q    <= 1'b0;
         frame_sad_q   <= 24'd0;
      end else begin
         state_q       <= state_d;
         mb_x_q        <= mb_x_d;
         mb_y_q        <= mb_y_d;
         wd_q          <= wd_d;
         res_sad_q     <= res_sad_d;
         res_timeout_q <= res_timeout_d;
         res_mb_x_q    <= res_mb_x_d;
         res_mb_y_q    <= res_mb_y_d;
         res_last_q    <= res_last_d;
         frame_sad_q   <= frame_sad_d;
      end
   end

   // Control outputs are pure decodes of the state register; no input reaches them combinationally.
   assign busy        = (state_q != S_IDLE);
   assign frame_done  = (state_q == S_DONE);
   assign load_req    = (state_q == S_LOAD);
   assign me_start    = (state_q == S_START);
   assign res_valid   = (state_q == S_EMIT);
   assign load_mb_x   = mb_x_q;
   assign load_mb_y   = mb_y_q;
   assign res_mb_x    = res_mb_x_q;
   assign res_mb_y    = res_mb_y_q;
   assign res_sad     = res_sad_q;
   assign res_timeout = res_timeout_q;
   assign res_last    = res_last_q;
   assign frame_sad   = frame_sad_q;

endmodule

// File: doc/me_frame_scheduler.md
# me_frame_scheduler

Frame-level scheduler for the motion-estimation core. On a frame start it walks every macroblock in raster order and, for each one, asks the search-window loader to stage the current and search pixel regions. It then pulses the ME core's `start`, captures the core's `min_sad` on `valid`, and hands a per-macroblock result downstream over a valid/ready channel. It also accumulates a frame SAD total and guards against a hung core with a watchdog.

## Interface
Parameters:
- `FRAME_W_MB`, default 20, frame width in macroblocks (1..255).
- `FRAME_H_MB`, default 15, frame height in macroblocks (1..255).
- `TIMEOUT`, default 4096, maximum cycles spent waiting for the ME result (2..65535).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `frame_start`  in  1  request to begin a frame; sampled in IDLE only.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse when the frame completes.
- `load_req`  out  1  asks the loader to stage the macroblock at `load_mb_x`/`load_mb_y`.
- `load_mb_x`, `load_mb_y`  out  8  coordinates of the macroblock being staged.
- `load_ack`  in  1  loader has finished staging.
- `me_start`  out  1  one-cycle start pulse to the ME core.
- `me_valid`  in  1  ME core result strobe.
- `me_min_sad`  in  16  ME core result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_mb_x`, `res_mb_y`  out  8  coordinates of the result's macroblock.
- `res_sad`  out  16  macroblock SAD.
- `res_timeout`  out  1  result was produced by the watchdog, not by the core.
- `res_last`  out  1  result belongs to the final macroblock of the frame.
- `frame_sad`  out  24  saturating frame SAD total.

## Operation
States: IDLE, LOAD, START, WAIT, EMIT, DONE.

- **IDLE**
  - `frame_start`=1 clears the counters and `frame_sad`, then moves to LOAD.
  - `frame_start` in any other state is ignored; there is no queuing.
- **LOAD**
  - `load_req`=1 and `load_mb_x`/`load_mb_y` hold the current coordinates.
  - Stays in LOAD until `load_ack`=1, then moves to START.
- **START**
  - `me_start`=1 for exactly this one cycle.
  - Clears the watchdog and moves to WAIT.
- **WAIT**
  - `me_valid`=1: capture `me_min_sad` into `res_sad`, set `res_timeout`=0, move to EMIT.
  - Watchdog reaches TIMEOUT-1 without `me_valid`: set `res_sad`=16'hFFFF, `res_timeout`=1, move to EMIT.
  - If `me_valid` arrives in the same cycle the watchdog expires, `me_valid` wins.
- **EMIT**
  - `res_valid`=1; all `res_*` outputs are stable until the handshake.
  - On `res_valid` && `res_ready`:
    - Add `res_sad` to `frame_sad`, saturating at 24'hFFFFFF. Timeout results are added as 16'hFFFF.
    - Advance the coordinates.
    - Move to DONE if the transferred result had `res_last`=1; otherwise move to LOAD.
- **DONE**
  - `frame_done`=1 for one cycle, then move to IDLE.
- **Coordinate advance**
  - If `mb_x`==FRAME_W_MB-1, then `mb_x`←0 and `mb_y`←`mb_y`+1; otherwise `mb_x`←`mb_x`+1.
  - `res_last` = (`mb_x`==FRAME_W_MB-1) && (`mb_y`==FRAME_H_MB-1).
- **Ignored inputs**
  - `me_valid` outside WAIT is ignored.
  - `load_ack` outside LOAD is ignored.
- **Hold values**
  - `frame_sad` holds its value in IDLE until the next accepted `frame_start`.
  - `res_*` data outputs hold their last values when `res_valid`=0.

## Timing
- **Reset**
  - `rst` at a clock edge forces IDLE in any state.
  - All outputs return to 0, including `load_mb_*`, `res_*`, `frame_sad` and the counters.
  - An in-flight macroblock is abandoned; no `frame_done` is produced.
- **Edge sequence.** With `frame_start` at edge t:
  - `load_req`=1 from t+1.
  - If `load_ack` is high at t+1, `me_start`=1 during t+2.
  - WAIT begins at t+3.
  - `me_valid` sampled at edge w gives `res_valid`=1 from w+1.
  - A handshake at edge h gives `load_req` (next macroblock) or `frame_done` from h+1.
- **Cost per macroblock.** Minimum scheduler overhead is 4 cycles beyond core latency and loader latency: LOAD, START, EMIT and one WAIT cycle.
- **Outputs are registered.** `res_valid` is a direct state decode; there is no combinational path from `res_ready` to `res_valid` or to the data outputs.
- **Watchdog.** A timeout result appears exactly TIMEOUT cycles after the WAIT entry edge.
- **`busy`.** High from the cycle after the accepting `frame_start` through the DONE cycle inclusive.

## Test plan
- **Nominal frame.** FRAME_W_MB=2, FRAME_H_MB=2; loader acks 1 cycle after request; core returns SADs 10, 20, 30, 40 after 5 cycles; `res_ready`=1.
  - Results arrive in order (0,0), (1,0), (0,1), (1,1).
  - `res_last` is set on the 4th result only.
  - `frame_sad`=100; one `frame_done` pulse.
- **Backpressure.** Hold `res_ready`=0 for 7 cycles on result 2.
  - `res_valid` and data stay stable throughout.
  - No `load_req` is raised until the handshake.
  - `frame_sad` increments only once.
- **Watchdog.** TIMEOUT=16; core never responds for MB (1,0).
  - Result `res_sad`=16'hFFFF with `res_timeout`=1, exactly 16 cycles after WAIT entry.
  - The frame continues with the next macroblock.
  - A late `me_valid` is ignored.
- **Saturation and wrap.** FRAME_W_MB=3, FRAME_H_MB=100; every SAD = 16'hFFFF.
  - `frame_sad` saturates at 24'hFFFFFF and does not wrap.
  - `mb_x` cycles 0, 1, 2, 0 and `mb_y` increments on each wrap.
- **Ignored inputs.**
  - `frame_start` pulsed mid-frame and `me_valid` pulsed during LOAD: no effect.
  - Same-cycle `me_valid` with watchdog expiry yields the core's SAD and `res_timeout`=0.
- **Reset mid-frame.** Assert `rst` during WAIT of MB (1,0).
  - Next cycle all outputs are 0 and the state is IDLE.
  - A new `frame_start` restarts at (0,0) with `frame_sad`=0.
